// File: rtl/fetch_pkg.sv
// Shared defaults and state encoding for the instruction fetch stage.
package fetch_pkg;

    localparam int          DEF_ADDR_W    = 64;
    localparam int          DEF_DATA_W    = 64;
    localparam int          DEF_MEM_DEPTH = 1024;
    localparam int unsigned DEF_RESET_PC  = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry FIFO holding returned instruction words with their PCs.
// Push and pop may coincide at any occupancy; flush empties it in one cycle.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic [ADDR_W-1:0] push_pc,
    input  logic              pop,
    input  logic              flush,
    output logic [1:0]        count,
    output logic [DATA_W-1:0] head_data,
    output logic [ADDR_W-1:0] head_pc
);

    logic [DATA_W-1:0] data0_q, data1_q;
    logic [ADDR_W-1:0] pc0_q, pc1_q;
    logic              wr_ptr_q, rd_ptr_q;
    logic [1:0]        count_q;

    // Storage, pointers and occupancy; flush only resets bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data0_q  <= '0;
            data1_q  <= '0;
            pc0_q    <= '0;
            pc1_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else if (flush) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr_q) begin
                    data1_q <= push_data;
                    pc1_q   <= push_pc;
                end else begin
                    data0_q <= push_data;
                    pc0_q   <= push_pc;
                end
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    assign count     = count_q;
    assign head_data = rd_ptr_q ? data1_q : data0_q;
    assign head_pc   = rd_ptr_q ? pc1_q   : pc0_q;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, issues reads to a 1-cycle registered memory and
// queues the returned words for decode behind a valid/ready handshake.
//
// state | meaning
// IDLE  | no new fetches issued; in-flight word still lands, queue drains
// RUN   | issue a fetch every cycle the credit check allows
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int              ADDR_W    = DEF_ADDR_W,
    parameter int              DATA_W    = DEF_DATA_W,
    parameter int              MEM_DEPTH = DEF_MEM_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              imem_enable,
    output logic              imem_read,
    output logic [DATA_W-1:0] imem_data_in,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [DATA_W-1:0] inst_data,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              busy
);

    // MEM_DEPTH is a power of two, so wrapping is a mask.
    localparam logic [ADDR_W-1:0] PC_MASK = ADDR_W'(MEM_DEPTH - 1);

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] pc_q;
    logic              pending_q;
    logic [ADDR_W-1:0] pend_pc_q;
    logic [1:0]        count;
    logic              pop;
    logic              issue;

    assign pop = inst_valid & inst_ready;

    // Next state and issue decision; the credit check counts the word in
    // flight so the queue can never be pushed while full without a pop.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: if (start && !stop) state_d = RUN;
            RUN:  if (stop)           state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (state_q == RUN && !redirect_valid &&
            (({1'b0, count} + {2'b00, pending_q}) < (3'd2 + {2'b00, pop}))) begin
            issue = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // PC and in-flight tracking; a redirect drops any pending response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= RESET_PC;
            pending_q <= 1'b0;
            pend_pc_q <= RESET_PC;
        end else if (redirect_valid) begin
            pc_q      <= redirect_pc & PC_MASK;
            pending_q <= 1'b0;
        end else begin
            pending_q <= issue;
            if (issue) begin
                pc_q      <= (pc_q + 1'b1) & PC_MASK;
                pend_pc_q <= pc_q;
            end
        end
    end

    fetch_queue #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_queue (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (pending_q & ~redirect_valid),
        .push_data(imem_rdata),
        .push_pc  (pend_pc_q),
        .pop      (pop & ~redirect_valid),
        .flush    (redirect_valid),
        .count    (count),
        .head_data(inst_data),
        .head_pc  (inst_pc)
    );

    assign inst_valid   = (count != 2'd0);
    assign imem_addr    = pc_q;
    assign imem_enable  = issue;
    assign imem_read    = 1'b1;
    assign imem_data_in = '0;
    assign busy         = (state_q == RUN) | pending_q | inst_valid;

endmodule
